// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell and a borrow register, LSB first.
// The start/busy/done handshake lets a sequencing FSM issue back-to-back operations.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | processing one bit per cycle, busy=1
// S_DONE | one-cycle done pulse, new results visible; start accepted as in idle
module serial_sub #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-2:0] d_acc;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             d_bit;
   logic             br_next;
   logic [WIDTH-1:0] d_next;

   // Operands shift right so the current bit is always at index 0; on the
   // last cycle index 0 therefore holds the captured operand MSBs.
   always_comb begin
      d_bit   = a_sh[0] ^ b_sh[0] ^ br;
      br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
      d_next  = {d_bit, d_acc};
   end

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         d_acc <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         diff  <= '0;
         bout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  br    <= bin;
                  cnt   <= '0;
                  state <= S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               br    <= br_next;
               d_acc <= d_next[WIDTH-1:1];
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state <= S_DONE;
                  diff  <= d_next;
                  bout  <= br_next;
                  ovf   <= (a_sh[0] != b_sh[0]) && (d_bit != a_sh[0]);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed cases, back-to-back starts, reset abort,
// exhaustive WIDTH=4 sweep and random WIDTH=8 operands against an integer model.
module tb_serial_sub;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       bin4 = 1'b0;
   logic       busy4, done4, bout4, ovf4;
   logic [3:0] diff4;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       bin8 = 1'b0;
   logic       busy8, done8, bout8, ovf8;
   logic [7:0] diff8;

   int total = 0;
   int bad = 0;
   int last_diff4 = 0;

   serial_sub #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
      .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
   );

   serial_sub #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: plain integer subtraction, borrow from sign of the true result,
   // overflow from the signs of the operands and the wrapped result.
   task automatic ref_sub(input int w, input int a, input int b, input int bin,
                          output int d, output int bo, output int ov);
      int r, sa, sb, sd;
      r  = a - b - bin;
      bo = (r < 0) ? 1 : 0;
      d  = r & ((1 << w) - 1);
      sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
      sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
      sd = (d >= (1 << (w - 1))) ? d - (1 << w) : d;
      ov = (((sa < 0) != (sb < 0)) && ((sd < 0) != (sa < 0))) ? 1 : 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts one WIDTH=4 operation; returns in the DONE cycle.
   task automatic op4(input int a, input int b, input int bin);
      int d, bo, ov, n, guard;
      ref_sub(4, a, b, bin, d, bo, ov);
      a4 = a[3:0]; b4 = b[3:0]; bin4 = bin[0]; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
      n = 0; guard = 0;
      while (busy4 && guard < 12) begin
         n++;
         chk("w4_busy_done_excl", done4, 0);
         chk("w4_diff_hold", diff4, last_diff4);
         tick();
         guard++;
      end
      chk("w4_busy_len", n, 4);
      chk("w4_done", done4, 1);
      chk("w4_diff", diff4, d);
      chk("w4_bout", bout4, bo);
      chk("w4_ovf", ovf4, ov);
      last_diff4 = d;
   endtask

   task automatic op8(input int a, input int b, input int bin);
      int d, bo, ov, n, guard;
      ref_sub(8, a, b, bin, d, bo, ov);
      a8 = a[7:0]; b8 = b[7:0]; bin8 = bin[0]; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
      n = 0; guard = 0;
      while (busy8 && guard < 20) begin
         n++;
         tick();
         guard++;
      end
      chk("w8_busy_len", n, 8);
      chk("w8_done", done8, 1);
      chk("w8_diff", diff8, d);
      chk("w8_bout", bout8, bo);
      chk("w8_ovf", ovf8, ov);
   endtask

   initial begin
      int qa[$], qb[$], qbin[$];
      int d, bo, ov, last_done, g;

      repeat (2) tick();
      rst = 1'b0;
      chk("rst_busy4", busy4, 0);
      chk("rst_done4", done4, 0);
      chk("rst_diff4", diff4, 0);
      chk("rst_bout4", bout4, 0);
      chk("rst_ovf4", ovf4, 0);
      chk("rst_busy8", busy8, 0);
      chk("rst_diff8", diff8, 0);

      // Directed cases; consecutive calls start from DONE.
      op4(4'b1010, 4'b1101, 0);
      op4(4'b0111, 4'b1000, 0);
      op4(4'b1000, 4'b0001, 0);
      op4(4'b0000, 4'b0000, 1);
      op4(4'b1011, 4'b1111, 0);
      tick();
      chk("idle_after_done", done4, 0);
      chk("idle_busy", busy4, 0);
      chk("idle_diff_hold", diff4, last_diff4);

      // start held high, operands changing every cycle.
      last_done = -1;
      start4 = 1'b1;
      for (int c = 0; c < 16; c++) begin
         a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
         if (!busy4) begin
            qa.push_back(int'(a4)); qb.push_back(int'(b4)); qbin.push_back(int'(bin4));
         end
         tick();
         if (done4) begin
            if (last_done >= 0) chk("b2b_spacing", c - last_done, 5);
            last_done = c;
            ref_sub(4, qa.pop_front(), qb.pop_front(), qbin.pop_front(), d, bo, ov);
            chk("b2b_diff", diff4, d);
            chk("b2b_bout", bout4, bo);
            chk("b2b_ovf", ovf4, ov);
            last_diff4 = d;
         end else if (busy4) begin
            chk("b2b_diff_hold", diff4, last_diff4);
         end
      end
      start4 = 1'b0;
      g = 0;
      while (busy4 && g < 10) begin
         tick();
         g++;
      end
      chk("b2b_drain_done", done4, 1);
      chk("b2b_queue_len", qa.size(), 1);
      if (qa.size() > 0) begin
         ref_sub(4, qa.pop_front(), qb.pop_front(), qbin.pop_front(), d, bo, ov);
         chk("b2b_last_diff", diff4, d);
         last_diff4 = d;
      end
      tick();

      // Reset in the 2nd RUN cycle aborts the operation.
      a4 = 4'b0011; b4 = 4'b0101; bin4 = 1'b0; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", busy4, 0);
      chk("abort_done", done4, 0);
      chk("abort_diff", diff4, 0);
      chk("abort_bout", bout4, 0);
      chk("abort_ovf", ovf4, 0);
      last_diff4 = 0;
      g = 0;
      for (int c = 0; c < 6; c++) begin
         if (done4) g++;
         tick();
      end
      chk("abort_no_done", g, 0);

      // Reset and start on the same edge: reset wins.
      rst = 1'b1; start4 = 1'b1;
      tick();
      rst = 1'b0; start4 = 1'b0;
      chk("rst_start_busy", busy4, 0);
      tick();
      chk("rst_start_idle", busy4, 0);

      op4(4'b0110, 4'b0010, 1);
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int bi = 0; bi < 2; bi++)
               op4(a, b, bi);

      op8(8'h00, 8'h00, 1);
      op8(8'h80, 8'h01, 0);
      op8(8'h7f, 8'hff, 0);
      for (int i = 0; i < 100; i++)
         op8(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
             int'($urandom_range(1, 0)));

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
